// File: rtl/c5315_alu_core.sv
// Dual 9-bit ALU derived from the c5315 benchmark: two independent lanes with
// flag, parity-check and aux-mixing side outputs, plus a registered output copy.
module c5315_alu_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [177:0] in_vec,
  output logic [122:0] out_vec,
  output logic [122:0] out_q
);

  // Even parity of a 9-bit word; also used as the result parity flag
  function automatic logic parity9(input logic [8:0] v);
    return ^v;
  endfunction

  // One lane: returns {co, res}; logic ops always report co=0
  function automatic logic [9:0] lane_alu(
    input logic [8:0] a,
    input logic [8:0] b,
    input logic [2:0] op,
    input logic       cin
  );
    logic [9:0] r;
    r = 10'd0;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b} + {9'd0, cin};
      3'b001:  r = {1'b0, a} + {1'b0, ~b} + {9'd0, cin};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, ~(a | b)};
      3'b110:  r = {1'b0, a};
      3'b111:  r = {1'b0, ~a};
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  logic [8:0]   a0_s, b0_s, a1_s, b1_s;
  logic [2:0]   op0_s, op1_s;
  logic         cin0_s, cin1_s;
  logic         pa0_s, pb0_s, pa1_s, pb1_s;
  logic [129:0] aux_s;

  assign a0_s   = in_vec[177:169];
  assign b0_s   = in_vec[168:160];
  assign a1_s   = in_vec[159:151];
  assign b1_s   = in_vec[150:142];
  assign op0_s  = in_vec[141:139];
  assign op1_s  = in_vec[138:136];
  assign cin0_s = in_vec[135];
  assign cin1_s = in_vec[134];
  assign pa0_s  = in_vec[133];
  assign pb0_s  = in_vec[132];
  assign pa1_s  = in_vec[131];
  assign pb1_s  = in_vec[130];
  assign aux_s  = in_vec[129:0];

  logic [9:0]  lane0_s, lane1_s;
  logic [8:0]  res0_s, res1_s;
  logic        co0_s, co1_s;
  logic        zero0_s, zero1_s;
  logic        par0_s, par1_s;
  logic [3:0]  perr_s;
  logic [94:0] misc_s;

  assign lane0_s = lane_alu(a0_s, b0_s, op0_s, cin0_s);
  assign lane1_s = lane_alu(a1_s, b1_s, op1_s, cin1_s);
  assign co0_s   = lane0_s[9];
  assign res0_s  = lane0_s[8:0];
  assign co1_s   = lane1_s[9];
  assign res1_s  = lane1_s[8:0];
  assign zero0_s = (res0_s == 9'd0);
  assign zero1_s = (res1_s == 9'd0);
  assign par0_s  = parity9(res0_s);
  assign par1_s  = parity9(res1_s);

  // A set bit flags a stored parity that disagrees with its operand
  assign perr_s = {parity9(a0_s) ^ pa0_s, parity9(b0_s) ^ pb0_s,
                   parity9(a1_s) ^ pa1_s, parity9(b1_s) ^ pb1_s};

  // Each low aux bit is mixed with one of 35 upper aux bits, cycling
  always_comb begin
    misc_s = 95'd0;
    for (int i = 0; i < 95; i++) begin
      misc_s[i] = aux_s[i] ^ aux_s[95 + (i % 35)];
    end
  end

  // Combinational output packing
  always_comb begin
    out_vec = {res0_s, res1_s, co0_s, co1_s, zero0_s, zero1_s,
               par0_s, par1_s, perr_s, misc_s};
  end

  logic [122:0] out_d;
  assign out_d = out_vec;

  // Registered copy of the combinational result, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 123'd0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_c5315_alu_core.sv
// Scoreboard bench for c5315_alu_core: expected results are computed from an
// independent reference model when stimulus is driven and popped when out_q loads.
module tb_c5315_alu_core;

  logic         clk;
  logic         rst_n;
  logic [177:0] in_vec;
  logic [122:0] out_vec;
  logic [122:0] out_q;

  int total;
  int bad;
  logic [122:0] exp_q[$];

  c5315_alu_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vec  (in_vec),
    .out_vec (out_vec),
    .out_q   (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference lane built from integer arithmetic
  function automatic logic [9:0] ref_lane(input int a, input int b, input int op, input int cin);
    int s;
    logic [8:0] la, lb, r;
    logic co;
    la = a[8:0];
    lb = b[8:0];
    co = 1'b0;
    r  = 9'd0;
    case (op)
      0: begin s = a + b + cin; co = (s >= 512); r = s[8:0]; end
      1: begin
        s = a - b - 1 + cin;
        co = (s >= 0);
        if (s < 0) s = s + 512;
        r = s[8:0];
      end
      2: r = la & lb;
      3: r = la | lb;
      4: r = la ^ lb;
      5: r = ~(la | lb);
      6: r = la;
      default: r = ~la;
    endcase
    return {co, r};
  endfunction

  function automatic logic [122:0] model(input logic [177:0] v);
    logic [9:0] l0, l1;
    logic [94:0] m;
    logic [129:0] aux;
    l0 = ref_lane(int'(v[177:169]), int'(v[168:160]), int'(v[141:139]), int'(v[135]));
    l1 = ref_lane(int'(v[159:151]), int'(v[150:142]), int'(v[138:136]), int'(v[134]));
    aux = v[129:0];
    for (int i = 0; i < 95; i++) m[i] = aux[i] ^ aux[95 + (i % 35)];
    return {l0[8:0], l1[8:0], l0[9], l1[9], (l0[8:0] == 9'd0), (l1[8:0] == 9'd0),
            ^l0[8:0], ^l1[8:0],
            (^v[177:169]) ^ v[133], (^v[168:160]) ^ v[132],
            (^v[159:151]) ^ v[131], (^v[150:142]) ^ v[130], m};
  endfunction

  function automatic logic [177:0] mk(input logic [8:0] a0, input logic [8:0] b0,
                                      input logic [8:0] a1, input logic [8:0] b1,
                                      input logic [2:0] op0, input logic [2:0] op1,
                                      input logic cin0, input logic cin1);
    return {a0, b0, a1, b1, op0, op1, cin0, cin1, 4'd0, 130'd0};
  endfunction

  task automatic drive(input logic [177:0] v);
    in_vec = v;
    exp_q.push_back(model(v));
  endtask

  task automatic test_reset();
    logic [122:0] k;
    k = 123'd0;
    k[102:101] = 2'b11;
    rst_n = 1'b0;
    in_vec = 178'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_q !== 123'd0) begin bad++; $display("FAIL reset_out_q got=%h want=0", out_q); end
    total++;
    if (out_vec !== k) begin bad++; $display("FAIL zero_vec got=%h want=%h", out_vec, k); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_q !== k) begin bad++; $display("FAIL first_load got=%h want=%h", out_q, k); end
  endtask

  task automatic test_boundaries();
    logic [122:0] e;
    drive(mk(9'h1FF, 9'h001, 9'd5, 9'd7, 3'b000, 3'b001, 1'b0, 1'b1));
    #1;
    total++;
    if (out_vec[122:99] !== {9'h000, 9'h1FE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_wrap_sub_neg got=%h want=%h", out_vec[122:99],
                      {9'h000, 9'h1FE, 6'b101000});
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (out_q !== e) begin bad++; $display("FAIL boundary_q got=%h want=%h", out_q, e); end
    drive(mk(9'h0A5, 9'h0A5, 9'h1FF, 9'h1FF, 3'b001, 3'b001, 1'b1, 1'b1));
    #1;
    total++;
    if (out_vec[122:101] !== {18'd0, 4'b1111}) begin
      bad++; $display("FAIL sub_equal got=%h want=%h", out_vec[122:101], {18'd0, 4'b1111});
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (out_q !== e) begin bad++; $display("FAIL sub_equal_q got=%h want=%h", out_q, e); end
  endtask

  task automatic test_logic_ops();
    logic [8:0] want [4];
    logic [122:0] e;
    want[0] = 9'h0F0; want[1] = 9'h0FF; want[2] = 9'h00F; want[3] = 9'h100;
    for (int k = 0; k < 4; k++) begin
      drive(mk(9'h0F0, 9'h0FF, 9'h0F0, 9'h0FF, 3'(k + 2), 3'(5 - k), 1'b1, 1'b1));
      #1;
      total++;
      if (out_vec[122:114] !== want[k] || out_vec[104] !== 1'b0) begin
        bad++; $display("FAIL logic_op%0d got=%h co=%b want=%h co=0", k + 2,
                        out_vec[122:114], out_vec[104], want[k]);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (out_q !== e) begin bad++; $display("FAIL logic_q%0d got=%h want=%h", k, out_q, e); end
    end
  endtask

  task automatic test_parity_misc();
    logic [177:0] v;
    logic [122:0] e;
    v = mk(9'h001, 9'h000, 9'h000, 9'h000, 3'b110, 3'b110, 1'b0, 1'b0);
    v[0] = 1'b1;
    v[95] = 1'b1;
    drive(v);
    #1;
    total++;
    if (out_vec[98:95] !== 4'b1000 || out_vec[0] !== 1'b0 || out_vec[35] !== 1'b1 ||
        out_vec[70] !== 1'b1) begin
      bad++; $display("FAIL perr_misc got perr=%b m0=%b m35=%b m70=%b want 1000 0 1 1",
                      out_vec[98:95], out_vec[0], out_vec[35], out_vec[70]);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (out_q !== e) begin bad++; $display("FAIL perr_q got=%h want=%h", out_q, e); end
  endtask

  task automatic test_back_to_back();
    logic [191:0] r;
    logic [122:0] e, ev;
    for (int n = 0; n < 40; n++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      drive(r[177:0]);
      ev = model(r[177:0]);
      #1;
      total++;
      if (out_vec !== ev) begin bad++; $display("FAIL rand_vec%0d got=%h want=%h", n, out_vec, ev); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (out_q !== e) begin bad++; $display("FAIL rand_q%0d got=%h want=%h", n, out_q, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [122:0] e;
    drive(mk(9'h123, 9'h045, 9'h1AA, 9'h055, 3'b000, 3'b100, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (out_q !== e) begin bad++; $display("FAIL pre_reset_q got=%h want=%h", out_q, e); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_q !== 123'd0) begin bad++; $display("FAIL async_clear got=%h want=0", out_q); end
    drive(mk(9'h0FF, 9'h101, 9'h003, 9'h1F0, 3'b011, 3'b001, 1'b0, 1'b1));
    @(posedge clk); #1;
    total++;
    if (out_q !== 123'd0) begin bad++; $display("FAIL held_reset got=%h want=0", out_q); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (out_q !== e) begin bad++; $display("FAIL post_release got=%h want=%h", out_q, e); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_boundaries();
    test_logic_ops();
    test_parity_misc();
    test_back_to_back();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
